serial_addsub: RTL and testbench
================================

# serial_addsub

- Parametrised bit-serial adder/subtractor; successor to the single-bit half-adder datapath.
- Adds or subtracts two WIDTH-bit operands over WIDTH/BITS_PER_CYCLE clock cycles, using one BITS_PER_CYCLE-wide adder slice and a carry flop.
- Operands enter and results leave through valid/ready handshakes.
- Intended to sit behind the TinyTapeout user-project wrapper, with operands fed from ui_in/uio_in staging registers.

## Interface

- WIDTH, 8: operand/result width; legal 2..32.
- BITS_PER_CYCLE, 1: bits processed per step; must divide WIDTH.
- STEPS (localparam) = WIDTH/BITS_PER_CYCLE.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B; sampled with operands.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out; for subtract, 1 = no borrow.
- ovf  output  1  signed overflow (see Configuration).

## Operation

- FSM states: IDLE, RUN, DONE. State and every output reset to 0/IDLE, asynchronously.
- Outputs after reset: in_ready=0 while rst is high, then 1 in IDLE; out_valid=0, sum=0, cout=0, ovf=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture A; capture B, inverted if sub=1; load carry=sub; clear step counter; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, add the low BITS_PER_CYCLE bits of the A and B shift registers plus carry.
  - Shift the slice result into the sum register from the MSB end; shift A and B right by BITS_PER_CYCLE; update carry; increment counter.
  - After step STEPS-1, latch cout=carry and go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - sum, cout and ovf held stable.
  - On out_ready: go to IDLE. New operands are not accepted in the same cycle.
- sum/cout/ovf keep the last result until the next completion; they are not cleared on return to IDLE.
- Inputs a, b and sub are ignored outside the accept cycle.
- Reset mid-RUN or mid-DONE: operation aborted, result discarded, all outputs return to reset values immediately.
- Arithmetic:
  - Add: sum = (a+b) mod 2^WIDTH, cout = bit WIDTH of a+b.
  - Subtract: sum = (a−b) mod 2^WIDTH, cout = (a ≥ b unsigned).

## Timing

- Accept at edge E0 (in_valid&in_ready high in the preceding cycle).
- RUN occupies edges E1..E_STEPS. out_valid rises after edge E_STEPS.
- Latency: STEPS+1 cycles from the accept cycle to the first out_valid cycle. WIDTH=8, BITS_PER_CYCLE=1 → 9 cycles.
- Minimum throughput: one operation per STEPS+2 cycles, with out_ready held high.
- out_valid stays high with no change in sum/cout/ovf until out_ready is seen at an edge; out_valid deasserts after that edge.
- in_ready is a combinational decode of state==IDLE and rst low. No other input-to-output combinational paths.

## Configuration

- SERADD_OVF_EN defined:
  - Carry into the MSB is captured on the final step.
  - ovf = carry_into_msb XOR cout, registered alongside cout.
- SERADD_OVF_EN undefined: the ovf port remains and is tied 0; no overflow logic is synthesised.

## Test plan

- WIDTH=8, BITS_PER_CYCLE=1, a=0x5A, b=0x3C, sub=0 → sum=0x96, cout=0, out_valid exactly 9 cycles after the accept cycle, in_ready low throughout.
- a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1. With SERADD_OVF_EN: ovf=0.
- a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0 (borrow). a=0x20, b=0x10, sub=1 → sum=0x10, cout=1.
- SERADD_OVF_EN: a=0x7F, b=0x01, sub=0 → sum=0x80, ovf=1. a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1. Without the macro, ovf=0 in both cases.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum and cout unchanged; in_ready=0; a/b changes ignored. Raise out_ready → IDLE next cycle.
- Reset: assert rst at step 4 of RUN → out_valid=0, sum=0, in_ready=1 after release. Then a new op completes correctly.
- Repeat the first scenario with BITS_PER_CYCLE=4 → latency 3 cycles, same sum=0x96.

Source files
------------

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand/result handshake bundle for serial_addsub.
// Operand side: in_valid, in_ready, a, b, sub.
// Result side: out_valid, out_ready, sum, cout, ovf.
// The master modport is the producer/consumer; the slave modport is the adder.
interface serial_addsub_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, BITS_PER_CYCLE bits per clock.
// Ports: clk, rst (async, active-high); io (serial_addsub_if.slave) carries
// in_valid/in_ready/a/b/sub on the operand side and
// out_valid/out_ready/sum/cout/ovf on the result side.
// Macro SERADD_OVF_EN enables the signed-overflow flag; otherwise ovf is 0.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave io
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [BPC-1:0]   slice;
  logic             slice_c, last, in_ready;
  assign in_ready     = state_q == IDLE && !rst;
  assign io.in_ready  = in_ready;
  assign io.out_valid = state_q == DONE;
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign last         = cnt_q == CW'(STEPS - 1);
  always_comb {slice_c, slice} = {1'b0, a_q[BPC-1:0]} + {1'b0, b_q[BPC-1:0]} + {{BPC{1'b0}}, carry_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (io.in_valid && in_ready) begin
      // subtraction is A + ~B + 1: invert B and seed the carry with sub
      a_d     = io.a;
      b_d     = io.sub ? ~io.b : io.b;
      carry_d = io.sub;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      // slice result enters at the MSB end so the final word is in order
      acc_d   = WIDTH'({slice, acc_q} >> BPC);
      a_d     = a_q >> BPC;
      b_d     = b_q >> BPC;
      carry_d = slice_c;
      cnt_d   = cnt_q + 1'b1;
      if (last) begin
        sum_d   = acc_d;
        cout_d  = slice_c;
        state_d = DONE;
      end
    end else if (state_q == DONE && io.out_ready) begin
      state_d = IDLE;
    end
  end
`ifdef SERADD_OVF_EN
  logic ovf_q, ovf_d, cin_msb;
  // carry into the slice MSB recovered from its sum bit and operand bits
  assign cin_msb = slice[BPC-1] ^ a_q[BPC-1] ^ b_q[BPC-1];
  always_comb ovf_d = state_q == RUN && last ? cin_msb ^ slice_c : ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign io.ovf = ovf_q;
`else
  assign io.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: drives an 8-bit/1-bit-per-cycle and an 8-bit/4-bit-per-cycle
// serial_addsub from the same stimulus and checks both against an arithmetic model.
module tb_serial_addsub;
`ifdef SERADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  serial_addsub_if #(.WIDTH(8)) i1 ();
  serial_addsub_if #(.WIDTH(8)) i4 ();
  assign i1.in_valid = in_valid;
  assign i1.a = a;
  assign i1.b = b;
  assign i1.sub = sub;
  assign i1.out_ready = out_ready;
  assign i4.in_valid = in_valid;
  assign i4.a = a;
  assign i4.b = b;
  assign i4.sub = sub;
  assign i4.out_ready = out_ready;
  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .io(i1));
  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .io(i4));
  typedef struct {
    logic [7:0] a, b;
    logic       sub;
    logic [7:0] sum;
    logic       cout, ovf;
  } vec_t;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input logic [7:0] x, y, input logic s,
                       output logic [7:0] es, output logic ec, output logic eo);
    int ux = x, uy = y, sx = $signed(x), sy = $signed(y), r;
    es = s ? 8'(ux - uy) : 8'(ux + uy);
    ec = s ? (ux >= uy) : (ux + uy > 255);
    r  = s ? sx - sy : sx + sy;
    eo = OVF_ON && (r > 127 || r < -128);
  endtask
  task automatic start(input logic [7:0] x, y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; in_valid = 1'b1;
    check("in_ready1_accept", i1.in_ready, 1);
    check("in_ready4_accept", i4.in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
  endtask
  task automatic op(input logic [7:0] x, y, input logic s,
                    input logic [7:0] es, input logic ec, eo);
    int n = 1;
    bit d1 = 0, d4 = 0;
    start(x, y, s);
    while (!(d1 && d4) && n < 40) begin
      if (!d1 && i1.out_valid) begin
        d1 = 1;
        check("lat1", n, 9);
        check("sum1", i1.sum, es);
        check("cout1", i1.cout, ec);
        check("ovf1", i1.ovf, eo);
      end else if (!d1) check("in_ready1_busy", i1.in_ready, 0);
      if (!d4 && i4.out_valid) begin
        d4 = 1;
        check("lat4", n, 3);
        check("sum4", i4.sum, es);
        check("cout4", i4.cout, ec);
        check("ovf4", i4.ovf, eo);
      end
      @(negedge clk);
      n++;
    end
    if (!(d1 && d4)) check("done_timeout", {d1, d4}, 2'b11);
  endtask
  initial begin
    vec_t vt[8];
    logic [7:0] es;
    logic ec, eo;
    int n;
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, OVF_ON};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vt[3] = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0};
    vt[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON};
    vt[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_ON};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
    #12;
    check("rst_in_ready", i1.in_ready, 0);
    check("rst_out_valid", i1.out_valid, 0);
    check("rst_sum", i1.sum, 0);
    check("rst_cout", i1.cout, 0);
    check("rst_ovf", i1.ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_in_ready", i1.in_ready, 1);
    foreach (vt[i]) op(vt[i].a, vt[i].b, vt[i].sub, vt[i].sum, vt[i].cout, vt[i].ovf);
    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    start(8'h5A, 8'h3C, 1'b0);
    n = 0;
    while (!i1.out_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_reach_done", i1.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      check("bp_out_valid", i1.out_valid, 1);
      check("bp_sum", i1.sum, 8'h96);
      check("bp_cout", i1.cout, 0);
      check("bp_in_ready", i1.in_ready, 0);
      check("bp_sum4", i4.sum, 8'h96);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", i1.out_valid, 0);
    check("bp_release_ready", i1.in_ready, 1);
    check("bp_sum_kept", i1.sum, 8'h96);
    // reset in the middle of RUN
    start(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", i1.out_valid, 0);
    check("mid_rst_sum", i1.sum, 0);
    check("mid_rst_in_ready", i1.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", i1.in_ready, 1);
    check("post_rst_valid", i1.out_valid, 0);
    check("post_rst_sum", i1.sum, 0);
    model(8'h33, 8'hC4, 1'b1, es, ec, eo);
    op(8'h33, 8'hC4, 1'b1, es, ec, eo);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] x, y;
      logic s;
      x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
      model(x, y, s, es, ec, eo);
      op(x, y, s, es, ec, eo);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
